// File: rtl/bip_exec_controller.sv
// bip_exec_controller: sequences the BIP from UART host commands.
// Gates the BIP execute enable (run / single step / host stop / stop on the
// HALT opcode) and streams a PC / INSTR / ACC snapshot to the UART
// transmitter one byte at a time, MSB first per field.
// Optional feature: define BIP_CYCLE_COUNT_EN to add a 16-bit count of
// executed instructions, appended to the snapshot frame as CNT[15:8], CNT[7:0].
module bip_exec_controller #(
    parameter int                    N_DATA             = 8,
    parameter int                    NB_DATABIP         = 16,
    parameter int                    LOG2_N_INSMEM_ADDR = 11,
    parameter int                    NB_OPCODE          = 5,
    parameter logic [NB_OPCODE-1:0]  HALT_OPCODE        = 5'b00000
) (
    input  logic                          i_clock,
    input  logic                          i_reset,
    input  logic [N_DATA-1:0]             i_rx_data,
    input  logic                          i_rx_done,
    input  logic                          i_tx_done,
    input  logic [LOG2_N_INSMEM_ADDR-1:0] i_pc,
    input  logic [NB_DATABIP-1:0]         i_instruction,
    input  logic [NB_DATABIP-1:0]         i_acc,
    output logic                          o_bip_valid,
    output logic [N_DATA-1:0]             o_tx_data,
    output logic                          o_tx_start,
    output logic                          o_halted,
    output logic                          o_busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RUN,
        ST_STEP,
        ST_SNAP,
        ST_SEND,
        ST_WAIT_TX
    } state_t;

    localparam logic [N_DATA-1:0] CMD_RUN  = N_DATA'(8'h52);  // 'R'
    localparam logic [N_DATA-1:0] CMD_STEP = N_DATA'(8'h53);  // 'S'
    localparam logic [N_DATA-1:0] CMD_DUMP = N_DATA'(8'h44);  // 'D'
    localparam logic [N_DATA-1:0] CMD_STOP = N_DATA'(8'h48);  // 'H'

`ifdef BIP_CYCLE_COUNT_EN
    localparam int CNT_W = 16;
`else
    localparam int CNT_W = 0;
`endif
    // Frame = PC zero-extended to 16 bits, instruction, ACC (+ counter).
    localparam int FRAME_W     = 16 + 2 * NB_DATABIP + CNT_W;
    localparam int FRAME_BYTES = FRAME_W / N_DATA;
    localparam int IDX_W       = $clog2(FRAME_BYTES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

    state_t               state_q;
    logic [FRAME_W-1:0]   snap_q;
    logic [IDX_W-1:0]     idx_q;
    logic [N_DATA-1:0]    tx_data_q;
    logic                 tx_start_q;
    logic                 halted_q;
    logic                 is_halt;
    logic [FRAME_W-1:0]   live_frame;

    // Byte idx of a frame, counted from the most significant end.
    function automatic logic [N_DATA-1:0] frame_byte(input logic [FRAME_W-1:0] f,
                                                     input logic [IDX_W-1:0]   idx);
        return f[(FRAME_BYTES - 1 - int'(idx)) * N_DATA +: N_DATA];
    endfunction

    assign is_halt = (i_instruction[NB_DATABIP-1 -: NB_OPCODE] == HALT_OPCODE);

`ifdef BIP_CYCLE_COUNT_EN
    logic [15:0] cnt_q;

    // Executed-instruction counter; wraps naturally, cleared only by reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            cnt_q <= '0;
        end else if (o_bip_valid) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign live_frame = {16'(i_pc), i_instruction, i_acc, cnt_q};
`else
    assign live_frame = {16'(i_pc), i_instruction, i_acc};
`endif

    // Command decode, run/step gating and byte-by-byte snapshot streaming.
    // tx_data/tx_start are loaded one edge early so they are valid in SEND.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            // NOTE: the snapshot is a plain register (not a RAM), so it is
            // reset along with the rest of the state to give a known dump.
            snap_q     <= '0;
            idx_q      <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments only in sequential logic, so every
            // register samples pre-edge values regardless of statement order.
            tx_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (i_rx_done) begin
                        if (i_rx_data == CMD_RUN && !halted_q) begin
                            state_q <= ST_RUN;
                        end else if (i_rx_data == CMD_STEP && !halted_q) begin
                            state_q <= ST_STEP;
                        end else if (i_rx_data == CMD_DUMP) begin
                            state_q <= ST_SNAP;
                        end
                    end
                end
                ST_RUN: begin
                    // HALT wins over a host stop arriving in the same cycle.
                    if (is_halt) begin
                        halted_q <= 1'b1;
                        state_q  <= ST_SNAP;
                    end else if (i_rx_done && i_rx_data == CMD_STOP) begin
                        state_q  <= ST_SNAP;
                    end
                end
                ST_STEP: begin
                    state_q <= ST_SNAP;
                end
                ST_SNAP: begin
                    snap_q     <= live_frame;
                    idx_q      <= '0;
                    tx_data_q  <= frame_byte(live_frame, '0);
                    tx_start_q <= 1'b1;
                    state_q    <= ST_SEND;
                end
                ST_SEND: begin
                    state_q <= ST_WAIT_TX;
                end
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        if (idx_q == LAST_IDX) begin
                            state_q <= ST_IDLE;
                        end else begin
                            idx_q      <= idx_q + 1'b1;
                            tx_data_q  <= frame_byte(snap_q, IDX_W'(idx_q + 1'b1));
                            tx_start_q <= 1'b1;
                            state_q    <= ST_SEND;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_bip_valid = ((state_q == ST_RUN) && !is_halt) || (state_q == ST_STEP);
    assign o_tx_data   = tx_data_q;
    assign o_tx_start  = tx_start_q;
    assign o_halted    = halted_q;
    assign o_busy      = (state_q != ST_IDLE);

endmodule
